prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; bit period DIV = CLK_FREQ/BAUD, integer-truncated.
REQ-003 Parameter ROM_DEPTH, default 4096, instruction-memory depth in 32-bit words.
REQ-004 Parameter TIMEOUT, default 1000000, maximum idle cycles between bytes inside a frame.
REQ-005 clk_100MHz  input  1  sole clock; all state updates on its rising edge.
REQ-006 arst  input  1  reset, asynchronous, active-high.
REQ-007 uart_rx_i  input  1  serial input: 8N1, LSB first, idle high.
REQ-008 hold_o  output  1  stalls the pipeline core while a program is loading.
REQ-009 rom_w_ena_o  output  1  single-cycle write strobe to instruction ROM.
REQ-010 rom_w_addr_o  output  32  byte address of the word being written.
REQ-011 rom_w_data_o  output  32  word being written.
REQ-012 boot_done_o  output  1  one-cycle pulse on a successful load.
REQ-013 boot_err_o  output  1  sticky error flag.

Function
REQ-014 Receiver: uart_rx_i passes through a 2-flop synchronizer; a high-to-low edge in idle starts a frame.
REQ-015 Receiver: the start bit is re-checked low at DIV/2; if it reads high, the receiver returns to idle with no byte delivered.
REQ-016 Receiver: data bits are sampled every DIV cycles after the start-bit mid-sample, LSB first; the stop bit is then sampled.
REQ-017 Receiver: a valid stop bit (1) produces a one-cycle byte-valid with the byte; a stop bit of 0 produces a framing-error pulse and no byte.
REQ-018 Loader FSM states: IDLE, LEN0, LEN1, DATA, CSUM, ERR.
REQ-019 IDLE: only byte 0xA5 moves the FSM to LEN0 and asserts hold_o; every other byte is ignored.
REQ-020 LEN0 and LEN1 capture word count N, low byte first (16 bits).
REQ-021 After LEN1: N > ROM_DEPTH goes to ERR; N = 0 goes to CSUM; otherwise the FSM goes to DATA.
REQ-022 DATA: bytes are assembled little-endian into a word; on the 4th byte, rom_w_ena_o pulses for exactly one cycle.
REQ-023 Write address: the first write uses address 0; each later write adds 4.
REQ-024 DATA ends and the FSM moves to CSUM after the Nth word is written.
REQ-025 Checksum: an 8-bit sum of all DATA bytes, modulo 256, cleared on header acceptance.
REQ-026 CSUM, byte equals sum: boot_done_o pulses for one cycle, hold_o drops the same cycle, and the FSM goes to IDLE.
REQ-027 CSUM, byte differs from sum: the FSM goes to ERR.
REQ-028 Framing error in LEN0, LEN1, DATA or CSUM goes to ERR; a framing error in IDLE is ignored.
REQ-029 Idle counter: clears on each byte-valid; when it reaches TIMEOUT in LEN0, LEN1, DATA or CSUM, the FSM goes to ERR.
REQ-030 ERR: asserts boot_err_o, keeps hold_o high and ignores all bytes except 0xA5.
REQ-031 ERR, byte 0xA5: restarts the frame as in IDLE and clears boot_err_o.
REQ-032 Writes already issued before an error are not retracted.
REQ-033 A byte-valid and a timeout in the same cycle resolve as the byte; timeout is not taken.

Reset
REQ-034 While arst is high: FSM = IDLE, receiver idle, all counters and the checksum = 0.
REQ-035 While arst is high: hold_o, rom_w_ena_o, boot_done_o and boot_err_o = 0; rom_w_addr_o and rom_w_data_o = 0.
REQ-036 Reset asserted mid-load aborts the load without a done or error indication.
REQ-037 After reset releases, the first falling edge on uart_rx_i is treated as a new start bit.

Structure
REQ-038 Header value 0xA5 and the FSM state encodings are defined in the shared define.v.
REQ-039 The receiver is one sub-module, uart_rx, with byte-valid, byte and framing-error outputs; it is reused for later UART peripherals.

Verification
REQ-040 Send A5 02 00, then 13 00 00 00 and 93 00 10 00, then checksum B6 -> writes (0x0,0x00000013) and (0x4,0x00100093); boot_done_o pulses once; hold_o falls.
REQ-041 Send the same frame with checksum B7 -> both writes occur; boot_err_o = 1; hold_o stays 1; a following good frame clears boot_err_o.
REQ-042 Send A5 01 11 (N = 0x1101 > 4096) -> ERR; no write strobe.
REQ-043 Send A5 00 00, then checksum 00 -> no writes; boot_done_o pulses.
REQ-044 Send A5 01 00 13, then stay silent for TIMEOUT cycles -> boot_err_o = 1; no write.
REQ-045 Send a byte with stop bit 0 in DATA -> ERR; assert arst mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
// The frame header byte and both FSM encodings live here so peripherals can share them.
package prog_loader_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_ERR
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // States in which a frame is in progress and the inter-byte timer runs.
  function automatic logic in_frame(ld_state_e s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer, start-bit re-check at mid-bit,
// and single-cycle byte-valid / framing-error pulses.
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);

  // sync_q[1] is the synchronized line, sync_q[2] its previous value for edge detection.
  logic [2:0]       sync_q, sync_d;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rx_s;
  logic             rx_prev;

  assign rx_s    = sync_q[1];
  assign rx_prev = sync_q[2];

  always_comb begin
    sync_d  = {sync_q[1:0], rx_i};
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_s) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          // A start bit that has gone high again by mid-bit is treated as a glitch.
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = rx_s;
          ferr_d  = !rx_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 3'b111;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_o       = shift_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// UART boot loader: receives an A5 / length / words / checksum frame and writes the
// words into instruction ROM while holding the core stalled.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 115200,
  parameter int ROM_DEPTH = 4096,
  parameter int TIMEOUT   = 1000000
) (
  input  logic        clk_100MHz,
  input  logic        arst,
  input  logic        uart_rx_i,
  output logic        hold_o,
  output logic        rom_w_ena_o,
  output logic [31:0] rom_w_addr_o,
  output logic [31:0] rom_w_data_o,
  output logic        boot_done_o,
  output logic        boot_err_o
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_ferr;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_uart_rx (
    .clk         (clk_100MHz),
    .rst         (arst),
    .rx_i        (uart_rx_i),
    .byte_valid_o(rx_valid),
    .byte_o      (rx_byte),
    .frame_err_o (rx_ferr)
  );

  ld_state_e         state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       next_addr_q, next_addr_d;
  logic [7:0]        csum_q, csum_d;
  logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic              hold_q, hold_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              w_ena_q, w_ena_d;
  logic [31:0]       w_addr_q, w_addr_d;
  logic [31:0]       w_data_q, w_data_d;

  logic              active;
  logic              timeout;
  logic [15:0]       n_words;
  logic [31:0]       asm_word;

  assign active   = in_frame(state_q);
  assign n_words  = {rx_byte, len_q[7:0]};
  assign asm_word = {rx_byte, word_q[31:8]};
  // A byte arriving in the same cycle as expiry wins over the timeout.
  assign timeout  = active && !rx_valid && (idle_cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    next_addr_d = next_addr_q;
    csum_d      = csum_q;
    hold_d      = hold_q;
    err_d       = err_q;
    done_d      = 1'b0;
    w_ena_d     = 1'b0;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;

    if (active && !rx_valid) begin
      idle_cnt_d = idle_cnt_q + TO_W'(1);
    end else begin
      idle_cnt_d = '0;
    end

    if (rx_valid) begin
      case (state_q)
        ST_IDLE, ST_ERR: begin
          if (rx_byte == HDR_BYTE) begin
            state_d     = ST_LEN0;
            hold_d      = 1'b1;
            err_d       = 1'b0;
            csum_d      = '0;
            word_cnt_d  = '0;
            byte_idx_d  = '0;
            next_addr_d = '0;
          end
        end
        ST_LEN0: begin
          len_d   = {8'h00, rx_byte};
          state_d = ST_LEN1;
        end
        ST_LEN1: begin
          len_d = n_words;
          if (32'(n_words) > 32'(ROM_DEPTH)) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else if (n_words == 16'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          word_d     = asm_word;
          csum_d     = csum_q + rx_byte;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            w_ena_d     = 1'b1;
            w_addr_d    = next_addr_q;
            w_data_d    = asm_word;
            next_addr_d = next_addr_q + 32'd4;
            word_cnt_d  = word_cnt_q + 16'd1;
            if ((word_cnt_q + 16'd1) == len_q) begin
              state_d = ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (rx_byte == csum_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if ((rx_ferr && active) || timeout) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
      hold_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz or posedge arst) begin
    if (arst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      next_addr_q <= '0;
      csum_q      <= '0;
      idle_cnt_q  <= '0;
      hold_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      w_ena_q     <= 1'b0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      next_addr_q <= next_addr_d;
      csum_q      <= csum_d;
      idle_cnt_q  <= idle_cnt_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
      done_q      <= done_d;
      w_ena_q     <= w_ena_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
    end
  end

  assign hold_o       = hold_q;
  assign boot_err_o   = err_q;
  assign boot_done_o  = done_q;
  assign rom_w_ena_o  = w_ena_q;
  assign rom_w_addr_o = w_addr_q;
  assign rom_w_data_o = w_data_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected ROM writes / done pulses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_prog_loader;

  localparam int CLK_FREQ  = 1000;
  localparam int BAUD      = 100;
  localparam int DIV       = CLK_FREQ / BAUD;
  localparam int ROM_DEPTH = 4096;
  localparam int TIMEOUT   = 300;

  logic        clk_100MHz = 1'b0;
  logic        arst       = 1'b1;
  logic        uart_rx_i  = 1'b1;
  logic        hold_o;
  logic        rom_w_ena_o;
  logic [31:0] rom_w_addr_o;
  logic [31:0] rom_w_data_o;
  logic        boot_done_o;
  logic        boot_err_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_done;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];

  prog_loader #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .ROM_DEPTH(ROM_DEPTH),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .arst        (arst),
    .uart_rx_i   (uart_rx_i),
    .hold_o      (hold_o),
    .rom_w_ena_o (rom_w_ena_o),
    .rom_w_addr_o(rom_w_addr_o),
    .rom_w_data_o(rom_w_data_o),
    .boot_done_o (boot_done_o),
    .boot_err_o  (boot_err_o)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    e.is_done = 1'b0;
    e.addr    = addr;
    e.data    = data;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    ev_t e;
    e.is_done = 1'b1;
    e.addr    = '0;
    e.data    = '0;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe or done pulse must match the head of the expected queue.
  always @(negedge clk_100MHz) begin
    if (!arst) begin
      if (rom_w_ena_o) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none",
                   rom_w_addr_o, rom_w_data_o);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("write_kind", {31'd0, e.is_done}, 32'd0);
          check("write_addr", rom_w_addr_o, e.addr);
          check("write_data", rom_w_data_o, e.data);
        end
      end
      if (boot_done_o) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("done_kind", {31'd0, e.is_done}, 32'd1);
          check("done_hold_low", {31'd0, hold_o}, 32'd0);
        end
      end
    end
  end

  task automatic bit_time();
    repeat (DIV) @(negedge clk_100MHz);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx_i = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      bit_time();
    end
    uart_rx_i = stop_bit;
    bit_time();
    uart_rx_i = 1'b1;
    bit_time();
  endtask

  // Two-word frame whose correct checksum is 0xB6.
  task automatic two_word_frame(input logic [7:0] csum, input bit expect_done);
    push_write(32'h0, 32'h0000_0013);
    push_write(32'h4, 32'h0010_0093);
    if (expect_done) push_done();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h93, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(csum, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hold"}, {31'd0, hold_o}, 32'd0);
    check({tag, "_ena"},  {31'd0, rom_w_ena_o}, 32'd0);
    check({tag, "_done"}, {31'd0, boot_done_o}, 32'd0);
    check({tag, "_err"},  {31'd0, boot_err_o}, 32'd0);
    check({tag, "_addr"}, rom_w_addr_o, 32'd0);
    check({tag, "_data"}, rom_w_data_o, 32'd0);
  endtask

  initial begin
    repeat (4) @(negedge clk_100MHz);
    check_all_zero("reset");
    arst = 1'b0;
    repeat (5) @(negedge clk_100MHz);

    // Short low glitch must not start a byte.
    uart_rx_i = 1'b0;
    repeat (2) @(negedge clk_100MHz);
    uart_rx_i = 1'b1;
    repeat (3 * DIV) @(negedge clk_100MHz);

    // Good two-word load.
    push_write(32'h0, 32'h0000_0013);
    push_write(32'h4, 32'h0010_0093);
    push_done();
    send_byte(8'hA5, 1'b1);
    check("hdr_hold_high", {31'd0, hold_o}, 32'd1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h93, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hB6, 1'b1);
    check("good_hold", {31'd0, hold_o}, 32'd0);
    check("good_err", {31'd0, boot_err_o}, 32'd0);

    // Bad checksum: writes still happen, error sticks, hold stays.
    two_word_frame(8'hB7, 1'b0);
    check("badsum_err", {31'd0, boot_err_o}, 32'd1);
    check("badsum_hold", {31'd0, hold_o}, 32'd1);
    send_byte(8'h13, 1'b1);
    check("err_ignores_byte", {31'd0, boot_err_o}, 32'd1);
    two_word_frame(8'hB6, 1'b1);
    check("recover_err", {31'd0, boot_err_o}, 32'd0);
    check("recover_hold", {31'd0, hold_o}, 32'd0);

    // Length too large.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1);
    check("toolong_err", {31'd0, boot_err_o}, 32'd1);
    check("toolong_hold", {31'd0, hold_o}, 32'd1);

    // Zero-length frame restarted from ERR.
    push_done();
    send_byte(8'hA5, 1'b1);
    check("restart_clears_err", {31'd0, boot_err_o}, 32'd0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check("zero_len_hold", {31'd0, hold_o}, 32'd0);

    // Inter-byte timeout inside DATA.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    check("pre_timeout_err", {31'd0, boot_err_o}, 32'd0);
    repeat (TIMEOUT + 100) @(negedge clk_100MHz);
    check("timeout_err", {31'd0, boot_err_o}, 32'd1);

    // Framing error in DATA.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    check("pre_ferr_err", {31'd0, boot_err_o}, 32'd0);
    send_byte(8'h55, 1'b0);
    check("ferr_err", {31'd0, boot_err_o}, 32'd1);

    // Reset in the middle of a data byte.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    uart_rx_i = 1'b0;
    repeat (3 * DIV) @(negedge clk_100MHz);
    check("pre_reset_hold", {31'd0, hold_o}, 32'd1);
    arst = 1'b1;
    #1;
    check_all_zero("midreset");
    uart_rx_i = 1'b1;
    repeat (5) @(negedge clk_100MHz);
    arst = 1'b0;
    repeat (5) @(negedge clk_100MHz);

    push_done();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check("post_reset_hold", {31'd0, hold_o}, 32'd0);

    repeat (20) @(negedge clk_100MHz);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
